// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit seven-segment scanner. It snapshots all eight patterns at frame start
// and can insert a blanking gap between digits so adjacent digits do not ghost.
module seg_scan_driver #(
    parameter int DIGIT_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int SEG_ACT_LOW  = 1,
    parameter int AN_ACT_LOW   = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] seg_0,
    input  logic [7:0] seg_1,
    input  logic [7:0] seg_2,
    input  logic [7:0] seg_3,
    input  logic [7:0] seg_4,
    input  logic [7:0] seg_5,
    input  logic [7:0] seg_6,
    input  logic [7:0] seg_7,
    output logic [7:0] seg_out,
    output logic [7:0] an_out,
    output logic [2:0] digit_idx,
    output logic       frame_done
);
    localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2((CNT_MAX < 2) ? 2 : CNT_MAX);

    localparam logic [CW-1:0] DIG_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;

    // XOR masks: a logical pattern XOR the mask gives the pin level, and the mask alone is OFF.
    localparam logic [7:0] SEG_INV = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [7:0] AN_INV  = (AN_ACT_LOW  != 0) ? 8'hFF : 8'h00;

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      idx_q;
    logic [7:0][7:0] shadow_q;
    logic [7:0]      seg_q;
    logic [7:0]      an_q;
    logic            fd_q;

    logic [7:0][7:0] seg_in;
    logic [2:0]      nxt_idx;
    logic            wrap;
    logic [7:0]      nxt_pat;
    logic            adv;

    assign seg_in = {seg_7, seg_6, seg_5, seg_4, seg_3, seg_2, seg_1, seg_0};

    // On the 7->0 wrap the fresh snapshot is taken on the same edge, so digit 0 reads the inputs.
    always_comb begin
        nxt_idx = idx_q + 3'd1;
        wrap    = (idx_q == 3'd7);
        nxt_pat = wrap ? seg_in[0] : shadow_q[nxt_idx];
        adv     = 1'b0;
        if (state_q == SHOW && cnt_q == DIG_LAST && BLANK_CYCLES == 0)
            adv = 1'b1;
        if (state_q == BLANK && cnt_q == BLK_LAST)
            adv = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            seg_q    <= SEG_INV;
            an_q     <= AN_INV;
            fd_q     <= 1'b0;
        end else if (!enable) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_INV;
            an_q    <= AN_INV;
            fd_q    <= 1'b0;
        end else if (adv) begin
            state_q <= SHOW;
            cnt_q   <= '0;
            idx_q   <= nxt_idx;
            seg_q   <= nxt_pat ^ SEG_INV;
            an_q    <= (8'h01 << nxt_idx) ^ AN_INV;
            fd_q    <= wrap;
            if (wrap)
                shadow_q <= seg_in;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q  <= SHOW;
                    cnt_q    <= '0;
                    idx_q    <= '0;
                    shadow_q <= seg_in;
                    seg_q    <= seg_in[0] ^ SEG_INV;
                    an_q     <= 8'h01 ^ AN_INV;
                    fd_q     <= 1'b0;
                end
                SHOW: begin
                    fd_q <= 1'b0;
                    if (cnt_q == DIG_LAST) begin
                        state_q <= BLANK;
                        cnt_q   <= '0;
                        seg_q   <= SEG_INV;
                        an_q    <= AN_INV;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                BLANK: begin
                    fd_q  <= 1'b0;
                    cnt_q <= cnt_q + CW'(1);
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    seg_q   <= SEG_INV;
                    an_q    <= AN_INV;
                    fd_q    <= 1'b0;
                end
            endcase
        end
    end

    assign seg_out    = seg_q;
    assign an_out     = an_q;
    assign digit_idx  = idx_q;
    assign frame_done = fd_q;
endmodule
